// File: rtl/load_size_unit.sv
// load_size_unit: multicycle word/half/byte load with a fixed memory latency.
// Define LOAD_SIGN_EXTEND_EN to add ls_signed, which sign-extends sub-word loads.
module load_size_unit #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  ls_control,
`ifdef LOAD_SIGN_EXTEND_EN
  input  logic        ls_signed,
`endif
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_word,
  output logic [31:0] load_data,
  output logic        done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt;
  logic [1:0]  size;
  logic        sgn;
  logic        last;
  logic [31:0] ext;
`ifdef LOAD_SIGN_EXTEND_EN
  logic size_signed;
  always_ff @(posedge clk)
    if (reset) size_signed <= 1'b0;
    else if (state == IDLE && start) size_signed <= ls_signed;
  assign sgn = size_signed;
`else
  assign sgn = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Lanes are always the low bits so loads line up with the store-size merge.
  always_comb begin
    last    = state == READ && cnt == 4'(MEM_LATENCY - 1);
    state_n = state == IDLE ? (start ? READ : IDLE) : state == READ ? (last ? DONE : READ) : IDLE;
    mem_rd  = state == READ;
    busy    = state != IDLE;
    done    = state == DONE;
    ext     = size == 2'd1 ? {{16{sgn & mem_rdata[15]}}, mem_rdata[15:0]} :
              size == 2'd2 ? {{24{sgn & mem_rdata[7]}}, mem_rdata[7:0]} : mem_rdata;
  end
  always_ff @(posedge clk)
    if (reset) begin
      mem_addr  <= '0;
      size      <= '0;
      cnt       <= '0;
      mem_word  <= '0;
      load_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        mem_addr <= addr;
        size     <= ls_control;
        cnt      <= '0;
      end else if (state == READ) cnt <= cnt + 4'd1;
      if (last) begin
        mem_word  <= mem_rdata;
        load_data <= ext;
      end
    end
endmodule

// File: tb/tb_load_size_unit.sv
// tb_load_size_unit: directed checks of load_size_unit at latencies 2, 1 and 15.
module tb_load_size_unit;
  logic        clk, reset, start;
  logic [31:0] addr, mem_rdata;
  logic [1:0]  ls_control;
`ifdef LOAD_SIGN_EXTEND_EN
  logic        ls_signed;
`endif
  logic [31:0] ma[3], mw[3], ld[3];
  logic        rd[3], dn[3], bz[3];
  int total = 0, bad = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  // instance 0: latency 2, instance 1: latency 1, instance 2: latency 15
  load_size_unit #(.MEM_LATENCY(2)) u0 (.clk(clk), .reset(reset), .start(start), .addr(addr),
    .ls_control(ls_control),
`ifdef LOAD_SIGN_EXTEND_EN
    .ls_signed(ls_signed),
`endif
    .mem_addr(ma[0]), .mem_rd(rd[0]), .mem_rdata(mem_rdata), .mem_word(mw[0]),
    .load_data(ld[0]), .done(dn[0]), .busy(bz[0]));
  load_size_unit #(.MEM_LATENCY(1)) u1 (.clk(clk), .reset(reset), .start(start), .addr(addr),
    .ls_control(ls_control),
`ifdef LOAD_SIGN_EXTEND_EN
    .ls_signed(ls_signed),
`endif
    .mem_addr(ma[1]), .mem_rd(rd[1]), .mem_rdata(mem_rdata), .mem_word(mw[1]),
    .load_data(ld[1]), .done(dn[1]), .busy(bz[1]));
  load_size_unit #(.MEM_LATENCY(15)) u2 (.clk(clk), .reset(reset), .start(start), .addr(addr),
    .ls_control(ls_control),
`ifdef LOAD_SIGN_EXTEND_EN
    .ls_signed(ls_signed),
`endif
    .mem_addr(ma[2]), .mem_rd(rd[2]), .mem_rdata(mem_rdata), .mem_word(mw[2]),
    .load_data(ld[2]), .done(dn[2]), .busy(bz[2]));

  function automatic int lat(input int k);
    return k == 0 ? 2 : k == 1 ? 1 : 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (bz[0] || bz[1] || bz[2]); i++) @(negedge clk);
    chk("idle", {29'd0, bz[2], bz[1], bz[0]}, 32'd0);
  endtask

  // Starts a load in the current negedge, drives valid data only in the capture cycle.
  task automatic do_load(input int k, input string nm, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] w, input logic [31:0] exp);
    int l, nrd, dcyc, ndn;
    logic addr_ok;
    l = lat(k); nrd = 0; dcyc = 0; ndn = 0; addr_ok = 1;
    start = 1; addr = a; ls_control = sz; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    start = 0; addr = 32'h0BAD0000;
    for (int n = 1; n <= l + 3; n++) begin
      mem_rdata = (n == l) ? w : 32'hBAD0BAD0;
      if (rd[k]) begin
        nrd++;
        if (ma[k] !== a) addr_ok = 0;
      end
      if (dn[k]) begin
        ndn++;
        if (dcyc == 0) dcyc = n;
      end
      if (n == l + 1) begin
        chk({nm, "_load_data"}, ld[k], exp);
        chk({nm, "_mem_word"}, mw[k], w);
        chk({nm, "_busy_done"}, {31'd0, bz[k]}, 32'd1);
      end
      if (n == l + 2) chk({nm, "_busy_after"}, {31'd0, bz[k]}, 32'd0);
      @(negedge clk);
    end
    chk({nm, "_rd_width"}, 32'(nrd), 32'(l));
    chk({nm, "_done_at"}, 32'(dcyc), 32'(l + 1));
    chk({nm, "_done_pulses"}, 32'(ndn), 32'd1);
    chk({nm, "_addr_hold"}, {31'd0, addr_ok}, 32'd1);
    wait_idle();
    chk({nm, "_hold"}, ld[k], exp);
  endtask

  initial begin
    logic [11:0] rdp, dnp, bzp, rdx, dnx, bzx;
    int ndn;
    start = 0; addr = 0; ls_control = 0; mem_rdata = 0; reset = 1;
`ifdef LOAD_SIGN_EXTEND_EN
    ls_signed = 0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_mem_addr", ma[0], 32'd0);
    chk("rst_mem_word", mw[0], 32'd0);
    chk("rst_load_data", ld[0], 32'd0);
    chk("rst_flags", {29'd0, rd[0], dn[0], bz[0]}, 32'd0);
    reset = 0;
    @(negedge clk);
    chk("idle_no_rd", {31'd0, rd[0]}, 32'd0);

    do_load(0, "word", 32'h100, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load(0, "half", 32'h104, 2'd1, 32'h1234F00D, 32'h0000F00D);
    do_load(0, "byte", 32'h108, 2'd2, 32'hAABBCC80, 32'h00000080);
    do_load(0, "half_hi", 32'h10C, 2'd1, 32'h00008001, 32'h00008001);
    do_load(0, "size3", 32'h110, 2'd3, 32'h87654321, 32'h87654321);
`ifdef LOAD_SIGN_EXTEND_EN
    ls_signed = 1;
    do_load(0, "sbyte", 32'h120, 2'd2, 32'hAABBCC80, 32'hFFFFFF80);
    do_load(0, "shalf", 32'h124, 2'd1, 32'h00008001, 32'hFFFF8001);
    do_load(0, "sword", 32'h128, 2'd0, 32'h80000001, 32'h80000001);
    do_load(0, "sbyte_pos", 32'h12C, 2'd2, 32'h000000FF7F, 32'h0000007F);
    ls_signed = 0;
`endif

    // start held high: accept, 2 READ, DONE, IDLE, then the next accept
    start = 1; addr = 32'h200; ls_control = 2'd0; mem_rdata = 32'h5555AAAA;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      rdp[n] = rd[0]; dnp[n] = dn[0]; bzp[n] = bz[0];
      rdx[n] = (n % 4) == 0 || (n % 4) == 1;
      dnx[n] = (n % 4) == 2;
      bzx[n] = (n % 4) != 3;
    end
    chk("hold_rd_pattern", {20'd0, rdp}, {20'd0, rdx});
    chk("hold_done_pattern", {20'd0, dnp}, {20'd0, dnx});
    chk("hold_busy_pattern", {20'd0, bzp}, {20'd0, bzx});
    chk("hold_mem_addr", ma[0], 32'h200);
    start = 0;
    wait_idle();

    // reset during the second READ cycle aborts the load
    start = 1; addr = 32'h300; ls_control = 2'd0; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("abort_in_read", {31'd0, rd[0]}, 32'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_flags", {29'd0, rd[0], dn[0], bz[0]}, 32'd0);
    chk("abort_load_data", ld[0], 32'd0);
    chk("abort_mem_word", mw[0], 32'd0);
    chk("abort_mem_addr", ma[0], 32'd0);
    ndn = 0;
    for (int n = 0; n < 5; n++) begin
      if (dn[0]) ndn++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndn), 32'd0);

    do_load(1, "lat1_word", 32'h400, 2'd0, 32'h0BADCAFE, 32'h0BADCAFE);
    do_load(1, "lat1_byte", 32'h404, 2'd2, 32'h123456F1, 32'h000000F1);
    do_load(2, "lat15_size3", 32'h500, 2'd3, 32'hFEEDFACE, 32'hFEEDFACE);
    do_load(2, "lat15_half", 32'h504, 2'd1, 32'hABCD8765, 32'h00008765);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
